io_bus_dma_master: RTL and testbench
====================================

# io_bus_dma_master

Bus initiator for the memory-mapped IO bus: on a start pulse it copies a block of bytes from a source page to a fixed destination window. It drives the address, read-strobe, write-strobe and tristate data lines that the IO-register responders and memory router decode. Its primary use is the GBC OAM DMA: the FF46 register's write strobe and value feed the start pulse and the source page, and the destination is FE00-FE9F.

## Interface
- P_LENGTH, 160: bytes per transfer; legal range 1..256.
- P_DST_BASE, 16'hFE00: destination address of byte 0.
- I_CLK  in  1  system clock; all logic is on the rising edge.
- I_SYNC_RESET  in  1  reset, synchronous and active-high.
- I_START  in  1  one-cycle start pulse, driven by the FF46 register's O_DBUS_WRITE.
- I_SRC_PAGE  in  8  source high byte, sampled when I_START is high.
- O_BUS_REQ  out  1  bus request to the arbiter.
- I_BUS_GNT  in  1  bus grant from the arbiter.
- O_ADDR_BUS  out  16  bus address.
- IO_DATA_BUS  inout  8  bus data; driven only during WRITE, otherwise Z.
- O_RE_BUS_L  out  1  read strobe, active low.
- O_WE_BUS_L  out  1  write strobe, active low.
- O_BUSY  out  1  high whenever the state is not IDLE.
- O_DONE  out  1  one-cycle pulse after the last byte is written.

## Operation
- Registers:
  - page (8 bits)
  - idx (8 bits)
  - data latch (8 bits)
  - state
- States and transitions:
  - IDLE: I_START -> WAIT_GNT; latch page = I_SRC_PAGE and set idx = 0.
  - WAIT_GNT: O_BUS_REQ = 1. If I_BUS_GNT -> READ.
  - READ:
    - Outputs: O_ADDR_BUS = {page, idx}, O_RE_BUS_L = 0, O_BUS_REQ = 1.
    - The data latch captures IO_DATA_BUS at the cycle-end edge.
    - Next state: WRITE.
  - WRITE:
    - Outputs: O_ADDR_BUS = P_DST_BASE + idx, O_WE_BUS_L = 0, data bus driven with the latch, O_BUS_REQ = 1.
    - At the cycle-end edge, idx is incremented.
    - If idx == P_LENGTH-1 (the last byte): go to IDLE and pulse O_DONE next cycle.
    - Otherwise, I_BUS_GNT high -> READ; I_BUS_GNT low -> WAIT_GNT.
- Grant rules:
  - Grant is sampled only in WAIT_GNT and at the end of WRITE.
  - A READ/WRITE pair is never split.
  - The arbiter must hold grant through any pair it has started.
- Outside READ/WRITE: O_RE_BUS_L = O_WE_BUS_L = 1, the data bus is Z, and O_ADDR_BUS holds 16'h0000.
- Width rules:
  - Source address = {page, idx}; it never carries into the page byte.
  - Destination address = P_DST_BASE + {8'h00, idx}, mod 2^16 (wraps FFFF -> 0000).
- Restart: I_START in any non-IDLE state relatches page and sets idx = 0, and the next state is WAIT_GNT. It overrides a READ/WRITE in the same cycle; that cycle's strobes still complete.
- I_START on the same edge as completion: restart wins and O_DONE is not pulsed.
- Reset:
  - Reset overrides everything, including mid-transfer.
  - Next cycle: state IDLE, strobes high, bus Z, O_BUS_REQ/O_BUSY/O_DONE 0, O_ADDR_BUS 0, page/idx/latch 0.

## Timing
- Strobes, address and O_BUS_REQ are registered (decoded from registered state); no combinational path from I_BUS_GNT to bus outputs.
- I_START at edge N: O_BUSY = 1 and O_BUS_REQ = 1 from cycle N+1.
- With grant held: first READ at N+2; 2 cycles per byte.
- Last WRITE ends at N+1+2·P_LENGTH; O_DONE is high the following cycle with O_BUSY = 0.
- Latency with grant held and P_LENGTH = 160: 322 cycles start-to-DONE.
- Read data is sampled at the end of the READ cycle; responders drive combinationally while the read strobe is low.
- Write data and address are stable for the whole WRITE cycle; the responder latches at its end.

## Structure
- Shared package io_bus_pkg holds:
  - state enum (IDLE, WAIT_GNT, READ, WRITE)
  - OAM constants: 16'hFE00 and 160
  - FF46 register address 16'hFF46
  - READ_ONLY/WRITE_ONLY mode codes, moved here so responders share them
- No sub-module; a single FSM plus counter is the natural size.

## Test plan
- Reset: hold I_SYNC_RESET 3 cycles -> all outputs at reset values, IO_DATA_BUS Z.
- Basic copy:
  - Setup: P_LENGTH = 4, source model C000-C003 = 11/22/33/44, grant tied high.
  - Stimulus: I_START with I_SRC_PAGE = C0.
  - Required: FE00-FE03 = 11/22/33/44; O_DONE at cycle N+10; exactly 4 RE and 4 WE strobes.
- Grant stall:
  - Stimulus: drop I_BUS_GNT after the 2nd WRITE for 5 cycles.
  - Required: WAIT_GNT for 5 cycles with no strobes, then resume at source idx 2 with correct data; O_DONE 5 cycles later than the basic copy.
- Restart:
  - Stimulus: I_START with page D0 at byte 80 of a C0 copy (P_LENGTH = 160).
  - Required: the next read address is D000; the full 160 bytes come from the D0 page; a single O_DONE.
- Mid-transfer reset: assert reset during a WRITE -> next cycle strobes high, bus Z, O_BUSY = 0, no O_DONE.
- Destination wrap:
  - Setup: P_DST_BASE = 16'hFFFE, P_LENGTH = 4.
  - Required: writes go to FFFE, FFFF, 0000, 0001 in order.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared definitions for the memory-mapped IO bus: initiator FSM states,
// OAM DMA constants, the FF46 register address and responder mode codes.
package io_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_GNT = 2'd1,
    ST_READ     = 2'd2,
    ST_WRITE    = 2'd3
  } dma_state_e;

  localparam logic [15:0] OAM_DST_BASE = 16'hFE00;
  localparam int          OAM_LENGTH   = 160;
  localparam logic [15:0] FF46_ADDR    = 16'hFF46;

  typedef enum logic [0:0] {
    READ_ONLY  = 1'b0,
    WRITE_ONLY = 1'b1
  } reg_mode_e;

  // Destination addresses wrap at 64K; idx is zero-extended, never sign-extended.
  function automatic logic [15:0] dst_addr(input logic [15:0] base, input logic [7:0] idx);
    return base + {8'h00, idx};
  endfunction

endpackage

// File: rtl/io_bus_dma_master.sv
// IO-bus DMA initiator: copies P_LENGTH bytes from page {page,00..} to a fixed
// destination window, one READ/WRITE pair per byte, with restart on I_START.
module io_bus_dma_master
  import io_bus_pkg::*;
#(
  parameter int          P_LENGTH   = OAM_LENGTH,
  parameter logic [15:0] P_DST_BASE = OAM_DST_BASE
) (
  input  logic        I_CLK,
  input  logic        I_SYNC_RESET,
  input  logic        I_START,
  input  logic [7:0]  I_SRC_PAGE,
  output logic        O_BUS_REQ,
  input  logic        I_BUS_GNT,
  output logic [15:0] O_ADDR_BUS,
  inout  wire  [7:0]  IO_DATA_BUS,
  output logic        O_RE_BUS_L,
  output logic        O_WE_BUS_L,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic [1:0]  O_DBG_STATE
);

  localparam logic [7:0] LAST_IDX = 8'(P_LENGTH - 1);

  dma_state_e state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] latch_q, latch_d;
  logic       done_q, done_d;

  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RESET) begin
      state_q <= ST_IDLE;
      page_q  <= '0;
      idx_q   <= '0;
      latch_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      latch_q <= latch_d;
      done_q  <= done_d;
    end
  end

  // Bus handshake: O_BUS_REQ is held from the start until the last WRITE.
  // I_BUS_GNT is sampled only in WAIT_GNT and at the end of WRITE, so a
  // READ/WRITE pair, once begun, always completes; the arbiter keeps grant
  // asserted across the pair.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    latch_d = latch_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_WAIT_GNT: begin
        if (I_BUS_GNT) state_d = ST_READ;
      end
      ST_READ: begin
        latch_d = IO_DATA_BUS;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        idx_d = idx_q + 8'd1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (I_BUS_GNT) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_WAIT_GNT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A new start wins over whatever the current pair would have done next,
    // including suppressing a completion on the same edge.
    if (I_START) begin
      state_d = ST_WAIT_GNT;
      page_d  = I_SRC_PAGE;
      idx_d   = '0;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    O_BUS_REQ   = (state_q != ST_IDLE);
    O_BUSY      = (state_q != ST_IDLE);
    O_RE_BUS_L  = (state_q != ST_READ);
    O_WE_BUS_L  = (state_q != ST_WRITE);
    O_DONE      = done_q;
    O_DBG_STATE = state_q;
    case (state_q)
      ST_READ:  O_ADDR_BUS = {page_q, idx_q};
      ST_WRITE: O_ADDR_BUS = dst_addr(P_DST_BASE, idx_q);
      default:  O_ADDR_BUS = 16'h0000;
    endcase
  end

  assign IO_DATA_BUS = (state_q == ST_WRITE) ? latch_q : 8'hzz;

endmodule

// File: tb/tb_io_bus_dma_master.sv
// Bench for io_bus_dma_master: three instances (short copy, full OAM copy,
// wrapping destination) against a source-memory model and expected write list.
module tb_io_bus_dma_master;
  import io_bus_pkg::*;

  localparam int NI = 3;
  localparam int          LEN_T  [NI] = '{4, OAM_LENGTH, 4};
  localparam logic [15:0] BASE_T [NI] = '{OAM_DST_BASE, OAM_DST_BASE, 16'hFFFE};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     [NI];
  logic       start   [NI];
  logic       gnt     [NI];
  logic [7:0] page_in [NI];
  wire [15:0] addr_o  [NI];
  wire        re_l_o  [NI];
  wire        we_l_o  [NI];
  wire        req_o   [NI];
  wire        busy_o  [NI];
  wire        done_o  [NI];
  wire [1:0]  st_o    [NI];
  wire [7:0]  bus_o   [NI];
  logic [7:0] seed8;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Source memory: the C000-C003 block is fixed, everything else is seeded.
  function automatic logic [7:0] src_byte(input logic [15:0] a, input logic [7:0] s);
    if (a[15:8] == 8'hC0 && a[7:0] < 8'd4) return 8'h11 * (a[7:0] + 8'd1);
    return (a[7:0] * 8'd3) ^ (a[15:8] * 8'd29) ^ s;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wire [7:0] bus_w;
    assign bus_w    = (re_l_o[g] == 1'b0) ? src_byte(addr_o[g], seed8) : 8'hzz;
    assign bus_o[g] = bus_w;
    io_bus_dma_master #(.P_LENGTH(LEN_T[g]), .P_DST_BASE(BASE_T[g])) u_dut (
      .I_CLK       (clk),
      .I_SYNC_RESET(rst[g]),
      .I_START     (start[g]),
      .I_SRC_PAGE  (page_in[g]),
      .O_BUS_REQ   (req_o[g]),
      .I_BUS_GNT   (gnt[g]),
      .O_ADDR_BUS  (addr_o[g]),
      .IO_DATA_BUS (bus_w),
      .O_RE_BUS_L  (re_l_o[g]),
      .O_WE_BUS_L  (we_l_o[g]),
      .O_BUSY      (busy_o[g]),
      .O_DONE      (done_o[g]),
      .O_DBG_STATE (st_o[g])
    );
  end

  // ---------------- monitor (active instance only) ----------------
  int act = 0;
  int re_cnt, we_cnt, done_cnt, wait_cnt, ovl_cnt;
  logic [15:0] rd_log[$];
  logic [23:0] wr_log[$];
  logic [23:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!re_l_o[act]) begin re_cnt++; rd_log.push_back(addr_o[act]); end
    if (!we_l_o[act]) begin we_cnt++; wr_log.push_back({addr_o[act], bus_o[act]}); end
    if (!re_l_o[act] && !we_l_o[act]) ovl_cnt++;
    if (busy_o[act] && re_l_o[act] && we_l_o[act]) wait_cnt++;
    if (done_o[act]) done_cnt++;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic bus_released(input int i);
    return (bus_o[i] === 8'hzz) || (bus_o[i] === 8'h00);
  endfunction

  task automatic check_idle(input int i);
    check_eq("idle_addr", addr_o[i], 16'h0000);
    check_eq("idle_re_l", re_l_o[i], 1'b1);
    check_eq("idle_we_l", we_l_o[i], 1'b1);
    check_eq("idle_req", req_o[i], 1'b0);
    check_eq("idle_busy", busy_o[i], 1'b0);
    check_eq("idle_done", done_o[i], 1'b0);
    check_eq("idle_state", st_o[i], ST_IDLE);
    check_eq("idle_bus_released", bus_released(i), 1'b1);
  endtask

  // Expected copy: byte k of page pg lands at base+k (mod 64K), in order.
  task automatic check_log(input logic [7:0] pg, input logic [15:0] base, input int len);
    exp_q.delete();
    for (int k = 0; k < len; k++)
      exp_q.push_back({base + 16'(k), src_byte({pg, 8'(k)}, seed8)});
    check_eq("wr_count", wr_log.size(), len);
    check_eq("rd_count", rd_log.size(), len);
    check_eq("strobe_overlap", ovl_cnt, 0);
    for (int k = 0; k < len; k++) begin
      logic [23:0] e;
      e = exp_q.pop_front();
      if (k < wr_log.size()) check_eq("wr_addr_data", wr_log[k], e);
      if (k < rd_log.size()) check_eq("rd_addr", rd_log[k], {pg, 8'(k)});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic clear_logs();
    re_cnt = 0; we_cnt = 0; done_cnt = 0; wait_cnt = 0; ovl_cnt = 0;
    rd_log.delete(); wr_log.delete();
  endtask

  // Returns n = index of the edge that samples the start pulse.
  task automatic start_pulse(input int i, input logic [7:0] pg, output int n);
    start[i]   = 1'b1;
    page_in[i] = pg;
    n = cyc + 1;
    @(posedge clk);
    #1;
    start[i]   = 1'b0;
    page_in[i] = 8'($urandom_range(0, 255));
  endtask

  // t = cycle in which O_DONE is seen (cycle k follows edge k-1), -1 on timeout.
  task automatic wait_done(input int i, input int n, input int stall, input bit rnd,
                           input int budget, output int t);
    t = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (stall > 0) begin
        if (cyc + 1 == n + 5)         gnt[i] = 1'b0;
        if (cyc + 1 == n + 5 + stall) gnt[i] = 1'b1;
      end
      if (rnd) gnt[i] = ($urandom_range(0, 3) != 0);
      if (done_o[i]) begin
        t = cyc + 1;
        check_eq("busy_at_done", busy_o[i], 1'b0);
        check_eq("bus_released_at_done", bus_released(i), 1'b1);
        break;
      end
    end
    gnt[i] = 1'b1;
    check_eq("done_seen", (t >= 0), 1'b1);
  endtask

  task automatic settle();
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, r, t;
    logic [7:0] pg, pg2;
    logic [15:0] wrap_addr [4];
    bit found;
    int nwr;

    seed8 = 8'($urandom_range(1, 255));
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; gnt[i] = 1'b0; page_in[i] = 8'h00;
    end
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) check_idle(i);

    // Basic copy: C000-C003 -> FE00-FE03, grant tied high.
    act = 0; gnt[0] = 1'b1;
    clear_logs();
    start_pulse(0, 8'hC0, n);
    @(negedge clk);
    check_eq("busy_after_start", busy_o[0], 1'b1);
    check_eq("req_after_start", req_o[0], 1'b1);
    check_eq("state_after_start", st_o[0], ST_WAIT_GNT);
    wait_done(0, n, 0, 1'b0, 100, t);
    check_eq("basic_done_cycle", t, n + 10);
    settle();
    check_eq("basic_done_count", done_cnt, 1);
    check_eq("basic_re_count", re_cnt, 4);
    check_eq("basic_we_count", we_cnt, 4);
    check_eq("basic_wait_cycles", wait_cnt, 1);
    for (int k = 0; k < 4; k++)
      if (k < wr_log.size()) check_eq("basic_data", wr_log[k][7:0], 8'h11 * 8'(k + 1));
    check_log(8'hC0, 16'hFE00, 4);

    // Grant dropped after the second WRITE for five cycles.
    clear_logs();
    pg = 8'($urandom_range(0, 255));
    start_pulse(0, pg, n);
    wait_done(0, n, 5, 1'b0, 100, t);
    check_eq("stall_done_cycle", t, n + 15);
    settle();
    check_eq("stall_wait_cycles", wait_cnt, 6);
    check_eq("stall_done_count", done_cnt, 1);
    check_log(pg, 16'hFE00, 4);

    // Restart landing on the completing edge: no done for the first copy.
    clear_logs();
    pg  = 8'($urandom_range(0, 255));
    pg2 = 8'($urandom_range(0, 255));
    start_pulse(0, pg, n);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (cyc + 1 == n + 9) break;
    end
    check_eq("collide_last_we", we_l_o[0], 1'b0);
    start_pulse(0, pg2, r);
    clear_logs();
    wait_done(0, r, 0, 1'b0, 100, t);
    check_eq("collide_done_cycle", t, r + 10);
    settle();
    check_eq("collide_done_count", done_cnt, 1);
    check_log(pg2, 16'hFE00, 4);

    // Random grant pattern: data and order must be unaffected.
    for (int it = 0; it < 4; it++) begin
      clear_logs();
      pg = 8'($urandom_range(0, 255));
      start_pulse(0, pg, n);
      wait_done(0, n, 0, 1'b1, 300, t);
      settle();
      check_eq("rand_latency_min", (t >= n + 10), 1'b1);
      check_eq("rand_done_count", done_cnt, 1);
      check_log(pg, 16'hFE00, 4);
    end

    // Reset asserted during a random WRITE of a copy.
    clear_logs();
    pg = 8'($urandom_range(0, 255));
    nwr = $urandom_range(1, 4);
    found = 1'b0;
    start_pulse(0, pg, n);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!we_l_o[0]) nwr--;
      if (nwr == 0) begin found = 1'b1; break; end
    end
    check_eq("write_before_reset", found, 1'b1);
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    clear_logs();
    @(negedge clk);
    check_idle(0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1;
    check_eq("reset_no_done", done_cnt, 0);
    check_eq("reset_no_we", we_cnt, 0);
    check_eq("reset_no_re", re_cnt, 0);

    // Full OAM copy from C0, restarted from D0 at byte 80.
    act = 1; gnt[1] = 1'b1;
    clear_logs();
    start_pulse(1, 8'hC0, n);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (cyc + 1 == n + 162) break;
    end
    check_eq("restart_read_addr", addr_o[1], 16'hC050);
    check_eq("restart_read_re_l", re_l_o[1], 1'b0);
    start_pulse(1, 8'hD0, r);
    clear_logs();
    wait_done(1, r, 0, 1'b0, 400, t);
    check_eq("oam_latency", t - r, 322);
    settle();
    if (rd_log.size() > 0) check_eq("restart_first_read", rd_log[0], 16'hD000);
    check_eq("restart_done_count", done_cnt, 1);
    check_log(8'hD0, 16'hFE00, 160);

    // Destination window wrapping past FFFF.
    act = 2; gnt[2] = 1'b1;
    wrap_addr[0] = 16'hFFFE; wrap_addr[1] = 16'hFFFF;
    wrap_addr[2] = 16'h0000; wrap_addr[3] = 16'h0001;
    clear_logs();
    pg = 8'($urandom_range(0, 255));
    start_pulse(2, pg, n);
    wait_done(2, n, 0, 1'b0, 100, t);
    check_eq("wrap_done_cycle", t, n + 10);
    settle();
    for (int k = 0; k < 4; k++)
      if (k < wr_log.size()) check_eq("wrap_addr", wr_log[k][23:8], wrap_addr[k]);
    check_log(pg, 16'hFFFE, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
